// File: rtl/i2c_pkg.sv
// Shared I2C target definitions: FSM state encoding and register indices.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package i2c_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_PTR,
    ST_PTR_ACK,
    ST_WDATA,
    ST_WDATA_ACK,
    ST_RDATA,
    ST_RACK
  } state_t;

  localparam logic [1:0] REG_CTRL0 = 2'd0;
  localparam logic [1:0] REG_CTRL1 = 2'd1;
  localparam logic [1:0] REG_CTRL2 = 2'd2;
  localparam logic [1:0] REG_STAT  = 2'd3;

endpackage

// File: rtl/i2c_bus_sync.sv
// Synchronises the async SCL/SDA pins and flags SCL edges plus START/STOP.
// Latency: events flag 2 clk_50m cycles after the pin change (plus one cycle of history).
// Backpressure: none; event flags are single-cycle pulses.
module i2c_bus_sync (
  input  logic clk_50m,
  input  logic reset,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);

  logic scl_s1, scl_s2, scl_d;
  logic sda_s1, sda_s2, sda_d;

  // Two flops per pin for metastability, one extra stage as edge history; idle bus level is high.
  always_ff @(posedge clk_50m) begin
    if (reset) begin
      scl_s1 <= 1'b1;
      scl_s2 <= 1'b1;
      scl_d  <= 1'b1;
      sda_s1 <= 1'b1;
      sda_s2 <= 1'b1;
      sda_d  <= 1'b1;
    end else begin
      scl_s1 <= scl_i;
      scl_s2 <= scl_s1;
      scl_d  <= scl_s2;
      sda_s1 <= sda_i;
      sda_s2 <= sda_s1;
      sda_d  <= sda_s2;
    end
  end

  assign sda       = sda_s2;
  assign scl_rise  =  scl_s2 & ~scl_d;
  assign scl_fall  = ~scl_s2 &  scl_d;
  // SDA may only move while SCL is high to signal START (falling) or STOP (rising).
  assign start_det =  scl_s2 & scl_d & sda_d & ~sda_s2;
  assign stop_det  =  scl_s2 & scl_d & ~sda_d & sda_s2;

endmodule

// File: rtl/i2c_target_regs.sv
// I2C target exposing three R/W control bytes and one read-only status byte via an auto-incrementing pointer.
// Latency: bus events act ~3 clk_50m cycles after the pin edge; wr_en pulses the cycle after the 8th data bit rise.
// Backpressure: none; the target never stretches SCL and the wr_* strobe cannot be stalled.
module i2c_target_regs #(
  parameter logic [6:0] DEV_ADDR = 7'h3C
) (
  input  logic        clk_50m,
  input  logic        reset,
  input  logic        scl_i,
  input  logic        sda_i,
  output logic        sda_o,
  output logic        sda_t,
  input  logic [7:0]  stat_i,
  output logic [23:0] ctrl_q,
  output logic        wr_en,
  output logic [1:0]  wr_idx,
  output logic [7:0]  wr_data
);
  import i2c_pkg::*;

  logic       sda_s, scl_rise, scl_fall, start_det, stop_det;
  state_t     state, state_n;
  logic [3:0] cnt, cnt_n;
  logic [7:0] sh, sh_n;
  logic       sda_t_n;
  logic [1:0] ptr, ptr_n;
  logic       mack, mack_n;
  logic       wr_go;
  logic [7:0] rx_byte, tx_byte;

  i2c_bus_sync u_sync (
    .clk_50m   (clk_50m),
    .reset     (reset),
    .scl_i     (scl_i),
    .sda_i     (sda_i),
    .sda       (sda_s),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det)
  );

  assign sda_o   = 1'b0;
  assign rx_byte = {sh[6:0], sda_s};

  // Byte to transmit for the current pointer; status is captured when this is loaded.
  always_comb begin
    tx_byte = stat_i;
    case (ptr)
      REG_CTRL0: tx_byte = ctrl_q[7:0];
      REG_CTRL1: tx_byte = ctrl_q[15:8];
      REG_CTRL2: tx_byte = ctrl_q[23:16];
      REG_STAT:  tx_byte = stat_i;
      default:   tx_byte = stat_i;
    endcase
  end

  // Protocol FSM: START/STOP first, then bit sampling on SCL rise and SDA updates on SCL fall.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    sh_n    = sh;
    sda_t_n = sda_t;
    ptr_n   = ptr;
    mack_n  = mack;
    wr_go   = 1'b0;
    if (stop_det) begin
      state_n = ST_IDLE;
      cnt_n   = 4'd0;
      sda_t_n = 1'b1;
    end else if (start_det) begin
      state_n = ST_ADDR;
      cnt_n   = 4'd0;
      sda_t_n = 1'b1;
    end else begin
      case (state)
        ST_ADDR, ST_PTR, ST_WDATA: begin
          if (scl_rise && cnt < 4'd8) begin
            sh_n  = rx_byte;
            cnt_n = cnt + 4'd1;
            if (state == ST_WDATA && cnt == 4'd7) begin
              wr_go = 1'b1;
              ptr_n = ptr + 2'd1;
            end
          end else if (scl_fall && cnt == 4'd8) begin
            cnt_n = 4'd0;
            if (state == ST_ADDR) begin
              // Mismatch leaves SDA released so the master sees a NACK.
              if (sh[7:1] == DEV_ADDR) begin
                state_n = ST_ADDR_ACK;
                sda_t_n = 1'b0;
              end else begin
                state_n = ST_IDLE;
              end
            end else if (state == ST_PTR) begin
              ptr_n   = sh[1:0];
              state_n = ST_PTR_ACK;
              sda_t_n = 1'b0;
            end else begin
              state_n = ST_WDATA_ACK;
              sda_t_n = 1'b0;
            end
          end
        end
        ST_ADDR_ACK: begin
          if (scl_fall) begin
            // R/W bit is the LSB of the address byte.
            if (sh[0]) begin
              state_n = ST_RDATA;
              sh_n    = tx_byte;
              sda_t_n = tx_byte[7];
            end else begin
              state_n = ST_PTR;
              sda_t_n = 1'b1;
            end
          end
        end
        ST_PTR_ACK, ST_WDATA_ACK: begin
          if (scl_fall) begin
            state_n = ST_WDATA;
            sda_t_n = 1'b1;
          end
        end
        ST_RDATA: begin
          if (scl_rise && cnt < 4'd8) begin
            cnt_n = cnt + 4'd1;
          end else if (scl_fall && cnt == 4'd8) begin
            state_n = ST_RACK;
            cnt_n   = 4'd0;
            sda_t_n = 1'b1;
            ptr_n   = ptr + 2'd1;
            mack_n  = 1'b0;
          end else if (scl_fall && cnt != 4'd0) begin
            sda_t_n = sh[6];
            sh_n    = {sh[6:0], 1'b0};
          end
        end
        ST_RACK: begin
          if (scl_rise) begin
            mack_n = ~sda_s;
          end else if (scl_fall) begin
            if (mack) begin
              state_n = ST_RDATA;
              sh_n    = tx_byte;
              sda_t_n = tx_byte[7];
            end else begin
              state_n = ST_IDLE;
              sda_t_n = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // FSM and shift/pointer state registers.
  always_ff @(posedge clk_50m) begin
    if (reset) begin
      state <= ST_IDLE;
      cnt   <= 4'd0;
      sh    <= 8'd0;
      sda_t <= 1'b1;
      ptr   <= 2'd0;
      mack  <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      sh    <= sh_n;
      sda_t <= sda_t_n;
      ptr   <= ptr_n;
      mack  <= mack_n;
    end
  end

  // Register file update and write strobe; index 3 strobes but is not stored.
  always_ff @(posedge clk_50m) begin
    if (reset) begin
      ctrl_q  <= 24'd0;
      wr_en   <= 1'b0;
      wr_idx  <= 2'd0;
      wr_data <= 8'd0;
    end else begin
      wr_en <= wr_go;
      if (wr_go) begin
        wr_idx  <= ptr;
        wr_data <= rx_byte;
        case (ptr)
          REG_CTRL0: ctrl_q[7:0]   <= rx_byte;
          REG_CTRL1: ctrl_q[15:8]  <= rx_byte;
          REG_CTRL2: ctrl_q[23:16] <= rx_byte;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_target_regs.sv
// Directed I2C master stimulus with a queue-based scoreboard for bus responses and write strobes.
module tb_i2c_target_regs;
  import i2c_pkg::*;

  localparam int Q = 10;

  logic        clk_50m = 1'b0;
  logic        reset   = 1'b1;
  logic        scl     = 1'b1;
  logic        sda_m   = 1'b1;
  logic [7:0]  stat_i  = 8'h3C;
  logic        sda_o, sda_t, wr_en;
  logic [23:0] ctrl_q;
  logic [1:0]  wr_idx;
  logic [7:0]  wr_data;
  logic        sda_bus;

  assign sda_bus = sda_m & (sda_t | sda_o);

  always #10 clk_50m = ~clk_50m;

  i2c_target_regs #(.DEV_ADDR(7'h3C)) dut (
    .clk_50m (clk_50m),
    .reset   (reset),
    .scl_i   (scl),
    .sda_i   (sda_bus),
    .sda_o   (sda_o),
    .sda_t   (sda_t),
    .stat_i  (stat_i),
    .ctrl_q  (ctrl_q),
    .wr_en   (wr_en),
    .wr_idx  (wr_idx),
    .wr_data (wr_data)
  );

  logic [31:0] exp_val[$];
  string       exp_tag[$];
  logic [31:0] act_val[$];
  logic [9:0]  exp_wr[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic        final_chk = 1'b0;
  logic        done = 1'b0;

  task automatic qw();
    repeat (Q) @(negedge clk_50m);
  endtask

  task automatic clk_bit(output logic s);
    qw(); scl = 1'b1;
    qw(); s = sda_bus;
    qw(); scl = 1'b0;
    qw();
  endtask

  task automatic bus_start();
    sda_m = 1'b1; qw();
    scl = 1'b1;   qw();
    sda_m = 1'b0; qw();
    scl = 1'b0;   qw();
  endtask

  task automatic bus_stop();
    sda_m = 1'b0; qw();
    scl = 1'b1;   qw();
    sda_m = 1'b1; qw();
  endtask

  task automatic expect_v(input string tag, input logic [31:0] v);
    exp_tag.push_back(tag);
    exp_val.push_back(v);
  endtask

  task automatic observe(input logic [31:0] v);
    act_val.push_back(v);
  endtask

  // Sends a byte; ack_lvl is the SDA level the target must present on the 9th clock.
  task automatic wr_byte(input logic [7:0] b, input logic ack_lvl, input string tag);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      sda_m = b[i];
      clk_bit(s);
    end
    sda_m = 1'b1;
    clk_bit(s);
    expect_v(tag, 32'(ack_lvl));
    observe(32'(s));
  endtask

  task automatic rd_byte(input logic [7:0] expb, input logic m_ack, input string tag);
    logic s;
    logic [7:0] d;
    d = 8'd0;
    sda_m = 1'b1;
    for (int i = 0; i < 8; i++) begin
      clk_bit(s);
      d = {d[6:0], s};
    end
    expect_v(tag, 32'(expb));
    observe(32'(d));
    sda_m = m_ack ? 1'b0 : 1'b1;
    clk_bit(s);
  endtask

  // Monitor: pairs expected/observed bus results, checks every wr_en strobe, drains at the end.
  initial begin
    forever begin
      @(negedge clk_50m);
      if (wr_en) begin
        n_cmp++;
        if (exp_wr.size() == 0) begin
          n_bad++;
          $display("FAIL wr_strobe: unexpected wr_en idx=%0d data=%02h", wr_idx, wr_data);
        end else begin
          logic [9:0] e;
          e = exp_wr.pop_front();
          if ({wr_idx, wr_data} !== e) begin
            n_bad++;
            $display("FAIL wr_strobe: got idx=%0d data=%02h, expected idx=%0d data=%02h",
                     wr_idx, wr_data, e[9:8], e[7:0]);
          end
        end
      end
      while (exp_val.size() > 0 && act_val.size() > 0) begin
        logic [31:0] e, a;
        string t;
        e = exp_val.pop_front();
        t = exp_tag.pop_front();
        a = act_val.pop_front();
        n_cmp++;
        if (a !== e) begin
          n_bad++;
          $display("FAIL %s: got %0h, expected %0h", t, a, e);
        end
      end
      if (final_chk && !done) begin
        while (exp_wr.size() > 0) begin
          logic [9:0] e;
          e = exp_wr.pop_front();
          n_cmp++;
          n_bad++;
          $display("FAIL wr_missing: no wr_en seen, expected idx=%0d data=%02h", e[9:8], e[7:0]);
        end
        if (exp_val.size() != act_val.size()) begin
          n_cmp++;
          n_bad++;
          $display("FAIL queue_drain: %0d expected vs %0d observed left", exp_val.size(), act_val.size());
        end
        done = 1'b1;
      end
    end
  end

  initial begin
    repeat (5) @(negedge clk_50m);
    reset = 1'b0;
    @(negedge clk_50m);
    expect_v("rst_sda_t", 32'd1);            observe(32'(sda_t));
    expect_v("rst_ctrl_q", 32'd0);           observe(32'(ctrl_q));
    expect_v("rst_wr_en", 32'd0);            observe(32'(wr_en));
    expect_v("rst_state", 32'(ST_IDLE));     observe(32'(dut.state));
    repeat (20) @(negedge clk_50m);

    // Write pointer 1, then two data bytes.
    bus_start();
    wr_byte(8'h78, 1'b0, "w1_addr_ack");
    wr_byte(8'h01, 1'b0, "w1_ptr_ack");
    exp_wr.push_back({2'd1, 8'hA5});
    wr_byte(8'hA5, 1'b0, "w1_d0_ack");
    exp_wr.push_back({2'd2, 8'h5A});
    wr_byte(8'h5A, 1'b0, "w1_d1_ack");
    bus_stop();
    qw();
    expect_v("w1_ctrl_q", 32'h005AA500);     observe(32'(ctrl_q));

    // Pointer 2, repeated START, read three bytes wrapping through status to reg0.
    bus_start();
    wr_byte(8'h78, 1'b0, "r1_addr_ack");
    wr_byte(8'h02, 1'b0, "r1_ptr_ack");
    bus_start();
    wr_byte(8'h79, 1'b0, "r1_raddr_ack");
    rd_byte(8'h5A, 1'b1, "r1_byte0");
    rd_byte(8'h3C, 1'b1, "r1_byte1");
    rd_byte(8'h00, 1'b0, "r1_byte2");
    expect_v("r1_state_idle", 32'(ST_IDLE)); observe(32'(dut.state));
    bus_stop();
    qw();

    // Foreign address: NACK and back to idle.
    bus_start();
    wr_byte(8'h7A, 1'b1, "na_addr_nack");
    expect_v("na_state", 32'(ST_IDLE));      observe(32'(dut.state));
    bus_stop();
    qw();

    // STOP after a partial data byte.
    bus_start();
    wr_byte(8'h78, 1'b0, "ps_addr_ack");
    wr_byte(8'h00, 1'b0, "ps_ptr_ack");
    begin
      logic s;
      sda_m = 1'b1; clk_bit(s);
      sda_m = 1'b0; clk_bit(s);
      sda_m = 1'b1; clk_bit(s);
      sda_m = 1'b0; clk_bit(s);
    end
    bus_stop();
    qw();
    expect_v("ps_state", 32'(ST_IDLE));      observe(32'(dut.state));
    expect_v("ps_ctrl_q", 32'h005AA500);     observe(32'(ctrl_q));

    // Write to the status index: ACKed and strobed, not stored.
    bus_start();
    wr_byte(8'h78, 1'b0, "st_addr_ack");
    wr_byte(8'h03, 1'b0, "st_ptr_ack");
    exp_wr.push_back({2'd3, 8'hFF});
    wr_byte(8'hFF, 1'b0, "st_data_ack");
    bus_stop();
    qw();
    expect_v("st_ctrl_q", 32'h005AA500);     observe(32'(ctrl_q));

    // Reset while the target drives a 0 bit in RDATA.
    bus_start();
    wr_byte(8'h78, 1'b0, "rr_addr_ack");
    wr_byte(8'h00, 1'b0, "rr_ptr_ack");
    bus_start();
    wr_byte(8'h79, 1'b0, "rr_raddr_ack");
    expect_v("rr_drive_low", 32'd0);         observe(32'(sda_t));
    reset = 1'b1;
    @(negedge clk_50m);
    expect_v("rr_sda_t", 32'd1);             observe(32'(sda_t));
    expect_v("rr_ctrl_q", 32'd0);            observe(32'(ctrl_q));
    expect_v("rr_state", 32'(ST_IDLE));      observe(32'(dut.state));
    reset = 1'b0;
    qw();
    scl = 1'b1;
    qw();
    sda_m = 1'b1;
    qw();

    // Target still works after the abort.
    bus_start();
    wr_byte(8'h78, 1'b0, "pr_addr_ack");
    wr_byte(8'h02, 1'b0, "pr_ptr_ack");
    exp_wr.push_back({2'd2, 8'h11});
    wr_byte(8'h11, 1'b0, "pr_data_ack");
    bus_stop();
    qw();
    expect_v("pr_ctrl_q", 32'h00110000);     observe(32'(ctrl_q));

    repeat (5) @(negedge clk_50m);
    final_chk = 1'b1;
    for (int i = 0; i < 50 && !done; i++) @(negedge clk_50m);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/i2c_target_regs.md
I2C_TARGET_REGS -- requirements
Module: i2c_target_regs

Interface
REQ-001 SHALL have parameter DEV_ADDR, default 7'h3C: 7-bit I2C target address.
REQ-002 SHALL have port clk_50m, input, 1: sole clock, 50 MHz, all logic rising-edge.
REQ-003 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-004 SHALL have port scl_i, input, 1: SCL pin value from the IOBUF O output, asynchronous.
REQ-005 SHALL have port sda_i, input, 1: SDA pin value from the IOBUF O output, asynchronous.
REQ-006 SHALL have port sda_o, output, 1: SDA drive value, constant 1'b0.
REQ-007 SHALL have port sda_t, output, 1: SDA tristate control; 1 = release, 0 = pull low.
REQ-008 SHALL have port stat_i, input, 8: read-only status byte, presented at register index 3.
REQ-009 SHALL have port ctrl_q, output, 24: registers 2..0 concatenated as {reg2, reg1, reg0}.
REQ-010 SHALL have port wr_en, output, 1: one-cycle pulse per accepted register write.
REQ-011 SHALL have port wr_idx, output, 2: register index of the write; valid only with wr_en.
REQ-012 SHALL have port wr_data, output, 8: data of the write; valid only with wr_en.

Function
REQ-013 SHALL pass scl_i and sda_i through 2-FF synchronizers plus one history stage, and detect edges on the synchronized signals.
REQ-014 SHALL detect START as synchronized SDA falling while SCL is high, and STOP as SDA rising while SCL is high.
REQ-015 SHALL implement these states: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RACK.
- START or repeated START in any state -> ADDR; bit counter cleared.
- STOP in any state -> IDLE; sda_t = 1.
REQ-016 SHALL sample SDA on SCL rising edges, MSB first, and change sda_t only on SCL falling edges.
REQ-017 SHALL, on address byte match with R/W = 0, ACK and enter PTR; on match with R/W = 1, ACK, then enter RDATA.
REQ-018 SHALL, on address mismatch, release SDA (NACK) and enter IDLE.
REQ-019 SHALL, in PTR, store byte[1:0] as pointer, ignore bits 7:2, ACK, and enter WDATA.
REQ-020 SHALL, on each WDATA byte, pulse wr_en in the cycle after the 8th-bit SCL rise, with wr_idx = pointer and wr_data = byte.
- Registers 0..2 update in that cycle.
- Index 3 writes are ignored for storage, still ACKed, and still strobe wr_en.
REQ-021 SHALL, in RDATA, drive the byte at pointer (index 3 returns stat_i captured at first SCL fall of the byte), releasing SDA for 1 bits.
REQ-022 SHALL increment the pointer modulo 4 after every written or read byte; 3 wraps to 0.
REQ-023 SHALL, in RACK, sample the master ACK: ACK -> next RDATA byte; NACK -> release SDA and IDLE.
REQ-024 SHALL, in the ACK state, drive sda_t = 0 from the SCL fall after bit 8 until the next SCL fall.
REQ-025 SHALL give START/STOP priority over a coincident SCL edge.
REQ-026 SHALL not stretch the clock; supported SCL is up to 400 kHz.

Reset
REQ-027 SHALL, while reset = 1, set state = IDLE, sda_t = 1, pointer = 0, ctrl_q = 0, wr_en = 0, wr_idx = 0, wr_data = 0, and synchronizer stages = 1.
REQ-028 SHALL, on reset asserted mid-transfer, abort the transfer and ignore the bus until the next START.

Structure
REQ-029 SHALL place the state enumeration and register index constants (REG_CTRL0..REG_STAT) in shared package i2c_pkg.
REQ-030 SHALL use one sub-module, i2c_bus_sync, holding the synchronizers and emitting scl_rise, scl_fall, start_det and stop_det.

Verification
REQ-031 SHALL cover: write 0x78, 0x01, 0xA5, 0x5A, STOP -> wr_en twice (idx 1 0xA5, idx 2 0x5A), ctrl_q = 24'h5AA500, all bytes ACKed.
REQ-032 SHALL cover: write 0x78, 0x02, repeated START, 0x79, read 3 bytes with ACK, ACK, NACK, stat_i = 0x3C -> reads 0x5A, 0x3C, 0x00 (wrap to 0).
REQ-033 SHALL cover: address 0x7A -> no ACK (SDA high at 9th clock), no wr_en, state IDLE.
REQ-034 SHALL cover: STOP injected after 4 data bits -> IDLE, no wr_en, registers unchanged.
REQ-035 SHALL cover: reset pulse during RDATA with SDA driven low -> sda_t = 1 the next cycle, ctrl_q = 0.
REQ-036 SHALL cover: write ptr 0x03, data 0xFF -> ACK, wr_en with idx 3, ctrl_q unchanged.
